// File: rtl/regfile_sb_pkg.sv
// Shared sizes and types for the register-file busy scoreboard.
package regfile_sb_pkg;

  localparam int NUM_REGS   = 128;
  localparam int NUM_WB     = 8;
  localparam int REG_ADDR_W = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   busy_vec_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue handshake and writeback-completion bundle between the issue stage,
// writeback lanes (master side) and the scoreboard (slave side).
interface regfile_scoreboard_if;
  import regfile_sb_pkg::*;

  logic                         issue_valid;
  logic                         issue_ready;
  reg_addr_t                    issue_rs1;
  reg_addr_t                    issue_rs2;
  logic                         issue_rs1_en;
  logic                         issue_rs2_en;
  reg_addr_t                    issue_rd;
  logic                         issue_rd_en;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr;
  logic                         flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
           issue_rd, issue_rd_en, wb_valid, wb_addr, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
           issue_rd, issue_rd_en, wb_valid, wb_addr, flush,
    output issue_ready
  );

endinterface

// File: rtl/regfile_sb_popcount.sv
// Combinational population count of a busy vector (0..128 fits in 8 bits).
module regfile_sb_popcount
  import regfile_sb_pkg::*;
(
  input  busy_vec_t  vec,
  output logic [7:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count = count + 8'(vec[i]);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-busy scoreboard and RAW/WAW issue gate.
// Optional SCOREBOARD_WB_BYPASS_EN lets same-cycle writebacks release hazards.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  regfile_scoreboard_if.slave sb,
  output busy_vec_t          busy_vec,
  output logic [7:0]         busy_count,
  output logic [CNT_W-1:0]   stall_count,
  output logic               wb_err
);

  busy_vec_t  wb_clear;
  busy_vec_t  hazard_busy;
  busy_vec_t  rd_set;
  busy_vec_t  busy_next;
  logic [7:0] count_next;
  logic       hazard;
  logic       fire;
  logic       wb_stray;

  // Duplicate lanes naming one register simply OR into the same bit.
  always_comb begin
    wb_clear = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (sb.wb_valid[i]) begin
        wb_clear[sb.wb_addr[REG_ADDR_W*i +: REG_ADDR_W]] = 1'b1;
      end
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign hazard_busy = busy_vec & ~wb_clear;
`else
  assign hazard_busy = busy_vec;
`endif

  assign hazard = (sb.issue_rs1_en & hazard_busy[sb.issue_rs1])
                | (sb.issue_rs2_en & hazard_busy[sb.issue_rs2])
                | (sb.issue_rd_en  & hazard_busy[sb.issue_rd]);

  assign sb.issue_ready = ~hazard & ~sb.flush;
  assign fire           = sb.issue_valid & sb.issue_ready;
  assign wb_stray       = |(wb_clear & ~busy_vec);

  // Set is applied after clear so a re-claim in the release cycle wins.
  always_comb begin
    rd_set = '0;
    if (fire && sb.issue_rd_en) begin
      rd_set[sb.issue_rd] = 1'b1;
    end
    busy_next = sb.flush ? '0 : ((busy_vec & ~wb_clear) | rd_set);
  end

  regfile_sb_popcount u_popcount (
    .vec   (busy_next),
    .count (count_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec    <= '0;
      busy_count  <= '0;
      stall_count <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy_vec   <= busy_next;
      busy_count <= count_next;
      if (sb.issue_valid && !sb.issue_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (wb_stray && !sb.flush) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default or bypass build).
module tb_regfile_scoreboard;
  import regfile_sb_pkg::*;

  logic             clock;
  logic             reset_n;
  busy_vec_t        busy_vec;
  logic [7:0]       busy_count;
  logic [31:0]      stall_count;
  logic             wb_err;
  int               check_count;
  int               pass_count;
  int               exp_stall;
  logic             exp_ready;

  regfile_scoreboard_if sb_if ();

  regfile_scoreboard #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sb          (sb_if.slave),
    .busy_vec    (busy_vec),
    .busy_count  (busy_count),
    .stall_count (stall_count),
    .wb_err      (wb_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic rs1_en, input reg_addr_t rs1,
                               input logic rd_en, input reg_addr_t rd);
    sb_if.issue_valid  = valid;
    sb_if.issue_rs1_en = rs1_en;
    sb_if.issue_rs1    = rs1;
    sb_if.issue_rd_en  = rd_en;
    sb_if.issue_rd     = rd;
    #1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    exp_stall   = 0;
    reset_n = 1'b0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_rs1 = '0;
    sb_if.issue_rs2 = '0;
    sb_if.issue_rs1_en = 1'b0;
    sb_if.issue_rs2_en = 1'b0;
    sb_if.issue_rd = '0;
    sb_if.issue_rd_en = 1'b0;
    sb_if.wb_valid = '0;
    sb_if.wb_addr = '0;
    sb_if.flush = 1'b0;

    #2;
    checkOutput("reset_busy_vec", busy_vec, 128'd0);
    checkOutput("reset_busy_count", busy_count, 128'd0);
    checkOutput("reset_stall", stall_count, 128'd0);
    checkOutput("reset_wb_err", wb_err, 128'd0);
    checkOutput("reset_ready", sb_if.issue_ready, 128'd1);
    #10 reset_n = 1'b1;

    $display("[TB] issue rd=5");
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 7'd5);
    checkOutput("rd5_ready", sb_if.issue_ready, 128'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    checkOutput("rd5_busy_vec", busy_vec, 128'd1 << 5);
    checkOutput("rd5_busy_count", busy_count, 128'd1);
    checkOutput("rd5_ready_after", sb_if.issue_ready, 128'd1);

    $display("[TB] RAW stall on rs1=5");
    applyStimulus(1'b1, 1'b1, 7'd5, 1'b0, 7'd0);
    checkOutput("raw_ready", sb_if.issue_ready, 128'd0);
    repeat (3) nextCycle();
    exp_stall = 3;
    checkOutput("raw_stall3", stall_count, 128'(exp_stall));
    sb_if.wb_valid = 8'b0000_1000;
    sb_if.wb_addr[REG_ADDR_W*3 +: REG_ADDR_W] = 7'd5;
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_ready = 1'b1;
`else
    exp_ready = 1'b0;
    exp_stall = exp_stall + 1;
`endif
    checkOutput("raw_ready_wb_cycle", sb_if.issue_ready, 128'(exp_ready));
    nextCycle();
    sb_if.wb_valid = '0;
    sb_if.wb_addr = '0;
    #1;
    checkOutput("raw_stall_after_wb", stall_count, 128'(exp_stall));
    checkOutput("raw_busy_cleared", busy_vec, 128'd0);
    checkOutput("raw_ready_after_wb", sb_if.issue_ready, 128'd1);
    nextCycle();
    checkOutput("raw_stall_after_fire", stall_count, 128'(exp_stall));
    checkOutput("raw_wb_err", wb_err, 128'd0);

    $display("[TB] WAW on rd=9");
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 7'd9);
    nextCycle();
    checkOutput("waw_busy9", busy_vec, 128'd1 << 9);
    checkOutput("waw_ready", sb_if.issue_ready, 128'd0);
    nextCycle();
    exp_stall = exp_stall + 1;
    checkOutput("waw_stall", stall_count, 128'(exp_stall));
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    sb_if.wb_valid = 8'b1000_0001;
    sb_if.wb_addr[0 +: REG_ADDR_W] = 7'd9;
    sb_if.wb_addr[REG_ADDR_W*7 +: REG_ADDR_W] = 7'd9;
    nextCycle();
    sb_if.wb_valid = '0;
    sb_if.wb_addr = '0;
    checkOutput("waw_busy_cleared", busy_vec, 128'd0);
    checkOutput("waw_count_zero", busy_count, 128'd0);
    checkOutput("waw_dup_lane_err", wb_err, 128'd0);
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'd9);
    checkOutput("waw_ready_again", sb_if.issue_ready, 128'd1);
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0);

    $display("[TB] stray writeback to 100");
    sb_if.wb_valid = 8'b0000_0100;
    sb_if.wb_addr[REG_ADDR_W*2 +: REG_ADDR_W] = 7'd100;
    nextCycle();
    sb_if.wb_valid = '0;
    sb_if.wb_addr = '0;
    checkOutput("stray_wb_err", wb_err, 128'd1);
    checkOutput("stray_count", busy_count, 128'd0);
    nextCycle();
    checkOutput("stray_wb_err_sticky", wb_err, 128'd1);

    $display("[TB] fill all 128 then flush");
    for (int i = 0; i < NUM_REGS; i++) begin
      applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 7'(i));
      nextCycle();
    end
    checkOutput("fill_count", busy_count, 128'd128);
    checkOutput("fill_vec", busy_vec, {128{1'b1}});
    checkOutput("fill_stall", stall_count, 128'(exp_stall));
    applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    sb_if.flush = 1'b1;
    #1;
    checkOutput("flush_ready", sb_if.issue_ready, 128'd0);
    nextCycle();
    sb_if.flush = 1'b0;
    exp_stall = exp_stall + 1;
    applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    checkOutput("flush_vec", busy_vec, 128'd0);
    checkOutput("flush_count", busy_count, 128'd0);
    checkOutput("flush_stall", stall_count, 128'(exp_stall));

    $display("[TB] async reset mid-stall");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 7'd0, 1'b1, 7'(i));
      nextCycle();
    end
    checkOutput("pre_reset_count", busy_count, 128'd40);
    applyStimulus(1'b1, 1'b1, 7'd3, 1'b0, 7'd0);
    repeat (2) nextCycle();
    exp_stall = exp_stall + 2;
    checkOutput("pre_reset_stall", stall_count, 128'(exp_stall));
    #3 reset_n = 1'b0;
    #1;
    checkOutput("async_busy_vec", busy_vec, 128'd0);
    checkOutput("async_busy_count", busy_count, 128'd0);
    checkOutput("async_stall", stall_count, 128'd0);
    checkOutput("async_wb_err", wb_err, 128'd0);
    checkOutput("async_ready", sb_if.issue_ready, 128'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
